// File: rtl/rca_pkg.sv
// Shared constants and types for the wide sequential adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rca_pkg;

  // Width of one adder slice.
  localparam int RCA_W = 64;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/rca_wide_add_seq_rca64.sv
// 64-bit ripple-carry adder slice: sum = a + b + cin, with carry out.
// Latency: purely combinational.
// Backpressure: none; always produces a result.
module RCA_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  logic c;

  // Ripple the carry bit by bit from LSB to MSB.
  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < 64; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rca_wide_add_seq.sv
// Wide add/subtract that time-shares one 64-bit RCA across WORDS slices, LSB first.
// Latency: out_valid rises WORDS cycles after the accept edge.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module rca_wide_add_seq
  import rca_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RCA_W*WORDS-1:0] A,
  input  logic [RCA_W*WORDS-1:0] B,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RCA_W*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   overflow
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);

  state_e                           state_q, state_d;
  logic [WORDS-1:0][RCA_W-1:0]      a_q, a_d;
  logic [WORDS-1:0][RCA_W-1:0]      b_q, b_d;
  logic [WORDS-1:0][RCA_W-1:0]      sum_q, sum_d;
  logic                             carry_q, carry_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic                             cout_q, cout_d;
  logic                             ovf_q, ovf_d;

  logic [RCA_W-1:0]                 rca_sum;
  logic                             rca_cout;

  // Single shared slice adder; operands come from the current slice index.
  RCA_64 u_rca (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (rca_sum),
    .cout (rca_cout)
  );

  // Next-state and datapath sequencing; everything holds unless the state acts on it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          // Subtraction is A + ~B + cin; inverting once here keeps RUN uniform.
          b_d     = sub ? ~B : B;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = rca_sum;
        carry_d      = rca_cout;
        idx_d        = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
          cout_d  = rca_cout;
          // Overflow uses the (possibly inverted) B that actually entered the adder.
          ovf_d   = (a_q[WORDS-1][RCA_W-1] == b_q[WORDS-1][RCA_W-1]) &&
                    (rca_sum[RCA_W-1] != a_q[WORDS-1][RCA_W-1]);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_rca_wide_add_seq.sv
// Directed bench for rca_wide_add_seq with WORDS=4.
// Latency: checks out_valid appears 4 cycles after accept.
// Backpressure: holds out_ready low and checks result stability.
module tb_rca_wide_add_seq;

  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_assert = 0;
  int n_fail   = 0;

  rca_wide_add_seq #(.WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one operation from IDLE through DONE and release it.
  task automatic do_op(input string tag,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sb,
                       input logic [W-1:0] exp_sum, input logic exp_cout,
                       input logic exp_ovf);
    int n;
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    A = a; B = b; cin = ci; sub = sb; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    A = '1; B = '1; cin = 1'b1; sub = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, W'(n), W'(4));
    chk({tag, "_sum"}, sum, exp_sum);
    chk({tag, "_cout"}, W'(cout), W'(exp_cout));
    chk({tag, "_ovf"}, W'(overflow), W'(exp_ovf));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_release_vld"}, W'(out_valid), W'(0));
    chk({tag, "_release_rdy"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] one;
    ones = '1;
    one  = W'(1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; cin = 1'b0; sub = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_in_ready", W'(in_ready), W'(1));
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_sum", sum, '0);
    chk("reset_cout", W'(cout), W'(0));
    chk("reset_ovf", W'(overflow), W'(0));

    // Reset together with in_valid must not accept.
    rst = 1'b1; in_valid = 1'b1; A = W'(9); B = W'(9);
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_vs_valid_rdy", W'(in_ready), W'(1));
    repeat (5) step();
    chk("rst_vs_valid_no_result", W'(out_valid), W'(0));

    do_op("cross_carry", W'(1), W'(64'hFFFF_FFFF_FFFF_FFFF), 1'b0, 1'b0,
          one << 64, 1'b0, 1'b0);
    do_op("full_cout", ones, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    do_op("sub_borrow", W'(5), W'(7), 1'b1, 1'b1, ones - W'(1), 1'b0, 1'b0);
    do_op("signed_ovf", (one << 255) - one, W'(1), 1'b0, 1'b0,
          one << 255, 1'b0, 1'b1);

    // Backpressure: hold the result while the requester keeps poking.
    A = W'(10); B = W'(20); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_valid", W'(out_valid), W'(1));
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      A = W'(100 + i); B = W'(200 + i); sub = i[1];
      step();
      chk("bp_sum_hold", sum, W'(30));
      chk("bp_cout_hold", W'(cout), W'(0));
      chk("bp_ovf_hold", W'(overflow), W'(0));
      chk("bp_in_ready", W'(in_ready), W'(0));
      chk("bp_out_valid", W'(out_valid), W'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_vld", W'(out_valid), W'(0));
    chk("bp_release_rdy", W'(in_ready), W'(1));
    do_op("bp_next_op", W'(64'h1234), W'(64'h1111), 1'b0, 1'b0,
          W'(64'h2345), 1'b0, 1'b0);

    // Reset on the second RUN cycle discards the operation.
    A = W'(8'hFF); B = W'(1); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    chk("midrst_sum", sum, '0);
    chk("midrst_cout", W'(cout), W'(0));
    chk("midrst_ovf", W'(overflow), W'(0));
    do_op("after_rst", W'(3), W'(4), 1'b0, 1'b0, W'(7), 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_wide_add_seq.md
# rca_wide_add_seq

Multi-cycle wide-operand adder/subtractor controller. It time-shares one `RCA_64` ripple-carry adder across `WORDS` 64-bit slices, LSB slice first, and carries the inter-slice carry in a register. It sits between a requesting unit and the shared 64-bit adder datapath, with valid/ready handshakes on both sides. The result is a `64*WORDS`-bit sum with unsigned carry-out and signed overflow.

## Interface
- `WORDS`, default 4: number of 64-bit slices; the operand width is `64*WORDS`; the legal range is ≥1.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: the requester presents an operation.
- `in_ready`, output, 1: the block can accept an operation; high only in IDLE.
- `A`, input, `64*WORDS`: operand A; sampled on accept.
- `B`, input, `64*WORDS`: operand B; sampled on accept.
- `cin`, input, 1: carry-in to the LSB slice; sampled on accept.
- `sub`, input, 1: 1 computes `A + ~B + cin`, so `cin`=1 gives `A−B`; sampled on accept.
- `out_valid`, output, 1: the result is valid.
- `out_ready`, input, 1: the consumer takes the result.
- `sum`, output, `64*WORDS`: registered result.
- `cout`, output, 1: carry out of the MSB slice. In subtract mode, 0 means a borrow occurred.
- `overflow`, output, 1: two's-complement overflow of the full-width operation.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE:** `in_ready`=1. On `in_valid & in_ready`, the block latches A, latches B (bitwise inverted when `sub`=1), latches `cin` into the carry register, and clears the slice index. It then moves to RUN.
- **RUN:** each cycle the adder inputs are `A_r[idx]`, `B_r[idx]` and the carry register.
  - At the edge, `sum[idx]` takes the adder sum, the carry register takes the adder `cout`, and idx increments.
  - When idx = WORDS−1, the FSM moves to DONE at that edge. `cout` and `overflow` are registered at the same edge.
- **DONE:** `out_valid`=1; `sum`, `cout` and `overflow` are held stable. On `out_ready`=1, the FSM moves to IDLE.
- A new operation cannot be accepted in the same cycle that DONE completes, because `in_ready`=0 outside IDLE.
- **Overflow:** `overflow = (A_r[MSB] == B_r[MSB]) && (sum[MSB] != A_r[MSB])`, using the possibly inverted B.
- While the FSM is not in IDLE, `in_valid` and the operand inputs are ignored.
- Index width is `max(1, $clog2(WORDS))`. With WORDS=1, RUN lasts exactly one cycle.
- The `sum` slices not yet written in the current operation hold stale data. `sum` is defined only while `out_valid`=1.

## Timing
- **Reset values:** state=IDLE, `in_ready`=1 from the cycle after `rst`, `out_valid`=0, `sum`=0, `cout`=0, `overflow`=0, carry register=0, idx=0.
- **Latency:** if the accept edge is edge t, `out_valid` rises after edge t+WORDS. It stays high until the edge where `out_ready`=1, then falls.
- **Minimum throughput:** one operation per WORDS+2 cycles (one accept cycle in IDLE, WORDS RUN cycles, at least one DONE cycle).
- `in_ready` is decoded combinationally from state. `out_valid`, `sum`, `cout` and `overflow` are registered.
- **Reset mid-operation:** `rst` in RUN or DONE forces IDLE at that edge. The partial result is discarded, `out_valid` is 0 the next cycle, and all outputs are zeroed.
- **`rst` with `in_valid`:** `rst` and `in_valid` high together means no accept; reset wins.

## Structure
- Shared package `rca_pkg`:
  - constant `RCA_W = 64`;
  - state enum `{IDLE, RUN, DONE}`.
- There is one sub-module: the existing `RCA_64`, instantiated unchanged. All sequencing is in this block.

## Test plan
All scenarios use WORDS=4.
- **Cross-slice carry:** A=1, B=2^64−1, cin=0, sub=0 → `sum`=2^64, `cout`=0, `overflow`=0. `out_valid` is first seen high 4 cycles after accept.
- **Full-width carry-out:** A=2^256−1, B=0, cin=1 → `sum`=0, `cout`=1, `overflow`=0.
- **Subtract with borrow:** A=5, B=7, sub=1, cin=1 → `sum`=2^256−2, `cout`=0, `overflow`=0.
- **Signed overflow:** A=2^255−1, B=1, cin=0 → `sum`=2^255, `overflow`=1, `cout`=0.
- **Backpressure:** hold `out_ready`=0 for 10 cycles after `out_valid`, and toggle `in_valid` with new operands meanwhile.
  - During the hold, `sum`, `cout` and `overflow` are stable and `in_ready`=0.
  - Then raise `out_ready` → `out_valid`=0 and `in_ready`=1 the next cycle.
  - The next accepted operation uses the operands present at that accept.
- **Reset mid-RUN:** pulse `rst` on the second RUN cycle → the next cycle shows `out_valid`=0, `in_ready`=1, `sum`=0. A follow-up op with A=3, B=4, cin=0 then yields `sum`=7.
